intfmux_arb: RTL



---
 rtl/intfmux_pkg.sv | 34 +++
 rtl/rr_pick.sv | 37 +++
 rtl/intfmux_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/intfmux_pkg.sv
// intfmux_pkg
// Shared definitions for the intfmux round-robin scheduler:
//   - state_t     : scheduler FSM encoding (IDLE / DRIVE / GAP)
//   - calc_*      : derivation of the word width and the serialization frame length
//   - idx_width   : clog2-style width of an index, never less than one bit
//   - wrap_idx    : (base + off) modulo n, used for round-robin pointer arithmetic
package intfmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // GAP is limited to 0..7, so a 3-bit idle counter always suffices.
    localparam int GAP_CNT_W = 3;

    function automatic int calc_databit(input int linebit, input int mux);
        return linebit * mux;
    endfunction

    function automatic int calc_frame(input int lat, input int mux, input int maxts);
        return lat + mux * maxts;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotate-priority encoder. Starting at ptr and moving upward
// (wrapping at NREQ), the first set request bit wins.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  PW    round-robin start position (always < NREQ)
//   winner out PW    index of the winning requester (0 when none)
//   valid  out 1     at least one request bit is set
module rr_pick
    import intfmux_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        logic [PW-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        // Walk from the farthest offset back to ptr itself; the nearest set
        // bit is written last and therefore wins, without needing a break.
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = PW'(wrap_idx(int'(ptr), off, NREQ));
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intfmux_arb.sv
// intfmux_arb
// Round-robin scheduler sharing one intfmux8-style serializer between NREQ
// parallel-word requesters. A granted word is latched onto mdat, a slow
// strobe (mclk) is generated for the mux to edge-detect, and the word is held
// for the whole frame. The mux's osyn is checked to arrive within LAT+1
// cycles of the strobe rise.
// Ports:
//   synclk  in  1             sole clock
//   rst     in  1             synchronous reset, active-high
//   en      in  1             1 = new grants allowed
//   req     in  NREQ          per-requester request level
//   dat     in  NREQ*DATABIT  requester words, requester i at [i*DATABIT +: DATABIT]
//   msyn    in  1             osyn returned from the mux
//   mclk    out 1             strobe to mux iclk
//   mdat    out DATABIT       word to mux idat
//   msel    out clog2(NREQ)   index of the requester being served
//   gnt     out NREQ          one-hot grant pulse
//   done    out 1             frame-complete pulse
//   busy    out 1             frame in progress
//   syncerr out 1             pulse, mux failed to sync
module intfmux_arb
    import intfmux_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LINEBIT = 1,
    parameter int MUX     = 8,
    parameter int MAXTS   = 6,
    parameter int CLKHI   = 3,
    parameter int LAT     = 3,
    parameter int GAP     = 2,
    parameter int DATABIT = calc_databit(LINEBIT, MUX),
    parameter int FRAME   = calc_frame(LAT, MUX, MAXTS)
) (
    input  logic                      synclk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATABIT-1:0]   dat,
    input  logic                      msyn,
    output logic                      mclk,
    output logic [DATABIT-1:0]        mdat,
    output logic [idx_width(NREQ)-1:0] msel,
    output logic [NREQ-1:0]           gnt,
    output logic                      done,
    output logic                      busy,
    output logic                      syncerr
);

    localparam int PW    = idx_width(NREQ);
    localparam int CW    = idx_width(FRAME);
    localparam int GW    = GAP_CNT_W;
    localparam int GAPM1 = (GAP > 0) ? GAP - 1 : 0;

    // Parameter sanity, caught at elaboration.
    if (FRAME - CLKHI + GAP < 2) begin : g_bad_low_time
        $error("intfmux_arb: FRAME-CLKHI+GAP must be >= 2 so the mux sees mclk low");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("intfmux_arb: NREQ must be 2..8");
    end
    if (MUX < 1 || MUX > 8) begin : g_bad_mux
        $error("intfmux_arb: MUX must be 1..8");
    end
    if (GAP < 0 || GAP > 7) begin : g_bad_gap
        $error("intfmux_arb: GAP must be 0..7");
    end
    if (CLKHI < 2 || CLKHI >= FRAME) begin : g_bad_clkhi
        $error("intfmux_arb: CLKHI must be >= 2 and shorter than the frame");
    end
    if (DATABIT != LINEBIT * MUX || FRAME != LAT + MUX * MAXTS) begin : g_bad_derived
        $error("intfmux_arb: DATABIT and FRAME are derived and must not be overridden");
    end

    // Split the flat requester bus into one word per requester.
    logic [DATABIT-1:0] word [NREQ];
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign word[gi] = dat[gi*DATABIT +: DATABIT];
    end

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [GW-1:0]   gap_cnt_reg;
    logic            seen_reg;     // msyn rise observed inside the current window
    logic            msyn_reg;     // previous msyn, for rising-edge detection
    logic            msyn_rise;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign cnt_next  = cnt_reg + CW'(1);
    assign msyn_rise = msyn & ~msyn_reg;

    always_ff @(posedge synclk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            gap_cnt_reg <= '0;
            seen_reg    <= 1'b0;
            msyn_reg    <= 1'b0;
            mclk        <= 1'b0;
            mdat        <= '0;
            msel        <= '0;
            gnt         <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            syncerr     <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            gnt      <= '0;
            done     <= 1'b0;
            syncerr  <= 1'b0;
            msyn_reg <= msyn;

            case (state_reg)
                ST_IDLE: begin
                    if (en && pick_valid) begin
                        gnt       <= NREQ'(1) << pick_idx;
                        mdat      <= word[pick_idx];
                        msel      <= pick_idx;
                        ptr_reg   <= PW'(wrap_idx(int'(pick_idx), 1, NREQ));
                        cnt_reg   <= '0;
                        seen_reg  <= 1'b0;
                        mclk      <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    // Sync window: the edges that sample counter values
                    // 0..LAT, i.e. the LAT+1 cycles following the mclk rise.
                    if (cnt_reg <= CW'(LAT)) begin
                        if (msyn_rise) begin
                            seen_reg <= 1'b1;
                        end
                        if (cnt_reg == CW'(LAT)) begin
                            syncerr <= ~(seen_reg | msyn_rise);
                        end
                    end

                    if (cnt_reg == CW'(FRAME - 1)) begin
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        mclk        <= 1'b0;
                        cnt_reg     <= '0;
                        gap_cnt_reg <= '0;
                        state_reg   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_next;
                        mclk    <= (cnt_next < CW'(CLKHI));
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GW'(GAPM1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
